wb_commit_queue: RTL

WB_COMMIT_QUEUE -- requirements
Module: wb_commit_queue

---
 rtl/wb_pkg.sv | 16 +
 rtl/wb_commit_queue_if.sv | 43 ++++
 rtl/wb_fifo.sv | 77 +++++++
 rtl/wb_commit_queue.sv | 81 ++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared types and widths for the writeback completion queue.
package wb_pkg;
    localparam int unsigned REG_W  = 6;
    localparam int unsigned ROB_W  = 6;
    localparam int unsigned DATA_W = 32;

    typedef struct packed {
        logic [ROB_W-1:0]  rob_ptr;
        logic [REG_W-1:0]  dst_reg;
        logic              wb;
        logic              taken;
        logic              hazard;
        logic [DATA_W-1:0] target;
        logic [DATA_W-1:0] data;
    } wb_entry_t;
endpackage

// File: rtl/wb_commit_queue_if.sv
// MEM/WB-side, ROB-side and register-file signals of the commit queue.
interface wb_commit_queue_if;
    import wb_pkg::*;

    logic              FREEZE;
    logic              FLUSH;
    logic              Valid_Instruction_IN;
    logic [DATA_W-1:0] result;
    logic [REG_W-1:0]  writeRegister1_PR;
    logic              do_writeback1_PR;
    logic              taken_branch1_IN;
    logic [DATA_W-1:0] target_PC_IN;
    logic              Mem_Hazard_IN;
    logic [ROB_W-1:0]  ROBPointer_IN;
    logic              ROB_Ready;

    logic              ROB_Valid;
    logic [ROB_W-1:0]  ROB_Ptr;
    logic              ROB_Taken;
    logic [DATA_W-1:0] ROB_Target;
    logic              ROB_Hazard;
    logic              RF_WE;
    logic [REG_W-1:0]  RF_Addr;
    logic [DATA_W-1:0] RF_Data;
    logic              Stall_OUT;
    logic              Overflow_OUT;

    modport master (
        output FREEZE, FLUSH, Valid_Instruction_IN, result, writeRegister1_PR,
               do_writeback1_PR, taken_branch1_IN, target_PC_IN, Mem_Hazard_IN,
               ROBPointer_IN, ROB_Ready,
        input  ROB_Valid, ROB_Ptr, ROB_Taken, ROB_Target, ROB_Hazard,
               RF_WE, RF_Addr, RF_Data, Stall_OUT, Overflow_OUT
    );

    modport slave (
        input  FREEZE, FLUSH, Valid_Instruction_IN, result, writeRegister1_PR,
               do_writeback1_PR, taken_branch1_IN, target_PC_IN, Mem_Hazard_IN,
               ROBPointer_IN, ROB_Ready,
        output ROB_Valid, ROB_Ptr, ROB_Taken, ROB_Target, ROB_Hazard,
               RF_WE, RF_Addr, RF_Data, Stall_OUT, Overflow_OUT
    );
endinterface

// File: rtl/wb_fifo.sv
// Circular completion-entry store with push/pop/flush and occupancy count.
module wb_fifo
    import wb_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   flush,
    input  wb_entry_t              wr_data,
    output wb_entry_t              rd_data,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    wb_entry_t        mem_q [DEPTH];
    wb_entry_t        mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push;
    logic             do_pop;

    // Guard locally so the store never corrupts itself whatever the caller does.
    assign do_pop  = pop && (count_q != '0) && !flush;
    assign do_push = push && !flush && (!full || do_pop);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = wr_data;
                wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Payload storage carries no reset; it is only observed behind a nonzero count.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign rd_data = mem_q[rd_ptr_q];
    assign count   = count_q;
    assign full    = (count_q == CNT_W'(DEPTH));
endmodule

// File: rtl/wb_commit_queue.sv
// Writeback completion queue between MEM/WB and the ROB, with RF write port,
// back-pressure and sticky overflow reporting.
module wb_commit_queue
    import wb_pkg::*;
#(
    parameter int unsigned DEPTH        = 4,
    parameter int unsigned STALL_THRESH = 3
) (
    input logic               CLK,
    input logic               RESET,
    wb_commit_queue_if.slave  bus
);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic [CNT_W-1:0] count;
    logic             full;
    wb_entry_t        head;
    wb_entry_t        new_entry;
    logic             rob_valid;
    logic             deq;
    logic             enq_attempt;
    logic             enq;
    logic             overflow_q, overflow_d;

    assign rob_valid   = (count != '0);
    assign deq         = rob_valid && bus.ROB_Ready && !bus.FLUSH;
    assign enq_attempt = bus.Valid_Instruction_IN && !bus.FREEZE && !bus.FLUSH;
    assign enq         = enq_attempt && (!full || deq);

    always_comb begin
        new_entry         = '0;
        new_entry.rob_ptr = bus.ROBPointer_IN;
        new_entry.dst_reg = bus.writeRegister1_PR;
        new_entry.wb      = bus.do_writeback1_PR;
        new_entry.taken   = bus.taken_branch1_IN;
        new_entry.hazard  = bus.Mem_Hazard_IN;
        new_entry.target  = bus.target_PC_IN;
        new_entry.data    = bus.result;
    end

    // A dropped enqueue latches the error until reset; flush leaves it alone.
    always_comb begin
        overflow_d = overflow_q;
        if (enq_attempt && full && !deq) begin
            overflow_d = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            overflow_q <= 1'b0;
        end else begin
            overflow_q <= overflow_d;
        end
    end

    wb_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (CLK),
        .rst     (RESET),
        .push    (enq),
        .pop     (deq),
        .flush   (bus.FLUSH),
        .wr_data (new_entry),
        .rd_data (head),
        .count   (count),
        .full    (full)
    );

    assign bus.ROB_Valid    = rob_valid;
    assign bus.ROB_Ptr      = head.rob_ptr;
    assign bus.ROB_Taken    = head.taken;
    assign bus.ROB_Target   = head.target;
    assign bus.ROB_Hazard   = head.hazard;
    assign bus.RF_WE        = deq && head.wb;
    assign bus.RF_Addr      = head.dst_reg;
    assign bus.RF_Data      = head.data;
    assign bus.Stall_OUT    = (32'(count) >= STALL_THRESH);
    assign bus.Overflow_OUT = overflow_q;
endmodule
